// File: rtl/dpram_wr_arbiter_ctrl.sv
// FIFO controller for an external simple dual-port RAM: round-robin write arbitration between
// two requesters and a prefetching valid/ready output register on the read side.
module dpram_wr_arbiter_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  s0_valid_i,
    input  logic [DATA_WIDTH-1:0] s0_data_i,
    output logic                  s0_ready_o,
    input  logic                  s1_valid_i,
    input  logic [DATA_WIDTH-1:0] s1_data_i,
    output logic                  s1_ready_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_src_o,
    input  logic                  m_ready_i,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  ram_wren_o,
    output logic [ADDR_WIDTH-1:0] ram_wraddress_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress_o,
    input  logic [DATA_WIDTH-1:0] ram_q_i
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LevelFull = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  prio_q, prio_d;
    logic                  fetch_pend_q, fetch_pend_d;
    logic                  tag_pend_q, tag_pend_d;
    logic [Depth-1:0]      src_tag_q, src_tag_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_src_q, m_src_d;

    logic full, grant0, grant1, grant, fetch;

    // Grants are gated by reset so every output reads 0 while rst_ni is held low.
    assign full   = (level_q == LevelFull);
    assign grant0 = rst_ni & ~full & s0_valid_i & (~prio_q | ~s1_valid_i);
    assign grant1 = rst_ni & ~full & s1_valid_i & (prio_q | ~s0_valid_i);
    assign grant  = grant0 | grant1;
    assign fetch  = (level_q != '0) & ~fetch_pend_q & (~m_valid_q | m_ready_i);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        prio_d       = prio_q;
        fetch_pend_d = fetch_pend_q;
        tag_pend_d   = tag_pend_q;
        src_tag_d    = src_tag_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_src_d      = m_src_q;

        if (grant) begin
            wr_ptr_d            = wr_ptr_q + ADDR_WIDTH'(1);
            prio_d              = grant0;
            src_tag_d[wr_ptr_q] = grant1;
        end

        // Capture and fetch are mutually exclusive since fetch needs !fetch_pend.
        if (fetch_pend_q) begin
            m_data_d     = ram_q_i;
            m_src_d      = tag_pend_q;
            m_valid_d    = 1'b1;
            fetch_pend_d = 1'b0;
        end else if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end

        if (fetch) begin
            rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
            fetch_pend_d = 1'b1;
            tag_pend_d   = src_tag_q[rd_ptr_q];
        end

        if (grant && !fetch) begin
            level_d = level_q + (ADDR_WIDTH + 1)'(1);
        end else if (!grant && fetch) begin
            level_d = level_q - (ADDR_WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            prio_q       <= 1'b0;
            fetch_pend_q <= 1'b0;
            tag_pend_q   <= 1'b0;
            src_tag_q    <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_src_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            prio_q       <= prio_d;
            fetch_pend_q <= fetch_pend_d;
            tag_pend_q   <= tag_pend_d;
            src_tag_q    <= src_tag_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_src_q      <= m_src_d;
        end
    end

    assign s0_ready_o      = grant0;
    assign s1_ready_o      = grant1;
    assign ram_wren_o      = grant;
    assign ram_wraddress_o = wr_ptr_q;
    assign ram_data_o      = grant0 ? s0_data_i : (grant1 ? s1_data_i : '0);
    assign ram_rdaddress_o = rd_ptr_q;
    assign level_o         = level_q;
    assign m_valid_o       = m_valid_q;
    assign m_data_o        = m_data_q;
    assign m_src_o         = m_src_q;

endmodule

// File: tb/tb_dpram_wr_arbiter_ctrl.sv
// Bench for dpram_wr_arbiter_ctrl: behavioural RAM model, accepted words queued as {src,data}
// and compared in order against every output handshake, plus directed checks.
module tb_dpram_wr_arbiter_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s0_valid = 1'b0, s1_valid = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] s0_data = '0, s1_data = '0;
    logic          s0_ready, s1_ready, m_valid, m_src, ram_wren;
    logic [DW-1:0] m_data, ram_data, ram_q;
    logic [AW:0]   level;
    logic [AW-1:0] ram_wraddress, ram_rdaddress;

    logic [DW-1:0] mem [2**AW];
    logic [DW:0]   sb [$];
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    dpram_wr_arbiter_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .s0_valid_i     (s0_valid),
        .s0_data_i      (s0_data),
        .s0_ready_o     (s0_ready),
        .s1_valid_i     (s1_valid),
        .s1_data_i      (s1_data),
        .s1_ready_o     (s1_ready),
        .m_valid_o      (m_valid),
        .m_data_o       (m_data),
        .m_src_o        (m_src),
        .m_ready_i      (m_ready),
        .level_o        (level),
        .ram_wren_o     (ram_wren),
        .ram_wraddress_o(ram_wraddress),
        .ram_data_o     (ram_data),
        .ram_rdaddress_o(ram_rdaddress),
        .ram_q_i        (ram_q)
    );

    // Simple dual-port RAM with registered read data.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        ram_q <= mem[ram_rdaddress];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (s0_valid && s0_ready) sb.push_back({1'b0, s0_data});
            if (s1_valid && s1_ready) sb.push_back({1'b1, s1_data});
        end
    end

    always @(negedge clk) begin
        logic [DW:0] exp_w;
        if (rst_n && m_valid && m_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got src=%0d data=%0h, required no output",
                         m_src, m_data);
            end else begin
                exp_w = sb.pop_front();
                if ({m_src, m_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL out_word: got src=%0d data=%0h, required src=%0d data=%0h",
                             m_src, m_data, exp_w[DW], exp_w[DW-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        m_ready = 1'b1;
        while ((sb.size() != 0 || level != '0 || m_valid) && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(n < 200), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_data"}, 64'(m_data), 64'd0);
        check({tag, "_m_src"}, 64'(m_src), 64'd0);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_ready"}, 64'({s0_ready, s1_ready}), 64'd0);
        check({tag, "_wren"}, 64'(ram_wren), 64'd0);
        check({tag, "_wdata"}, 64'(ram_data), 64'd0);
        check({tag, "_addrs"}, 64'({ram_wraddress, ram_rdaddress}), 64'd0);
    endtask

    initial begin
        int  idx;
        int  cyc;
        int  ngr;
        logic acc;
        logic exp_src;

        // Reset state, with a requester already valid.
        s0_valid = 1'b1;
        s0_data  = 32'h1234;
        #12;
        check_reset_outputs("rst_init");
        s0_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single word: accepted at E, visible after E+2.
        s0_valid = 1'b1;
        s0_data  = 32'hDEADBEEF;
        m_ready  = 1'b1;
        #1;
        check("t2_s0_ready", 64'({s0_ready, s1_ready}), 64'b10);
        check("t2_wren", 64'(ram_wren), 64'd1);
        check("t2_wdata", 64'(ram_data), 64'hDEADBEEF);
        tick();
        s0_valid = 1'b0;
        check("t2_level_e", 64'(level), 64'd1);
        check("t2_mvalid_e", 64'(m_valid), 64'd0);
        tick();
        check("t2_level_e1", 64'(level), 64'd0);
        check("t2_mvalid_e1", 64'(m_valid), 64'd0);
        tick();
        check("t2_mvalid_e2", 64'(m_valid), 64'd1);
        check("t2_mdata_e2", 64'(m_data), 64'hDEADBEEF);
        check("t2_msrc_e2", 64'(m_src), 64'd0);
        tick();
        check("t2_consumed", 64'(m_valid), 64'd0);

        // Backpressure: capacity is DEPTH in RAM plus one in the output register.
        m_ready  = 1'b0;
        s0_valid = 1'b1;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            s0_data = 32'(idx + 1);
            #1;
            acc = s0_ready;
            tick();
            if (acc) idx++;
        end
        check("t4_accepted", 64'(idx), 64'd3);
        #1;
        check("t4_blocked", 64'(s0_ready), 64'd0);
        check("t4_level_full", 64'(level), 64'd2);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 64'(m_valid), 64'd1);
            check("t4_hold_data", 64'(m_data), 64'h1);
            check("t4_hold_src", 64'(m_src), 64'd0);
            tick();
        end
        m_ready = 1'b1;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 20) begin
            #1;
            acc = s0_ready;
            tick();
            cyc++;
        end
        check("t4_fourth_accepted", 64'(acc), 64'd1);
        s0_valid = 1'b0;
        drain("t4_drain");

        // Ten words from s1 across pointer wraps, consumer toggling.
        s1_valid = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 100) begin
            s1_data = 32'(idx);
            m_ready = cyc[0];
            #1;
            acc = s1_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        s1_valid = 1'b0;
        check("t5_all_accepted", 64'(idx), 64'd10);
        drain("t5_drain");

        // Last grant was s1, so prio=0; lone s1 is still granted immediately.
        s1_valid = 1'b1;
        s1_data  = 32'h66;
        #1;
        check("t6_lone_s1", 64'({s0_ready, s1_ready}), 64'b01);
        @(posedge clk);
        #1;
        s0_valid = 1'b1;
        s0_data  = 32'h77;
        s1_data  = 32'h88;
        #1;
        check("t6_prio_back_s0", 64'({s0_ready, s1_ready}), 64'b10);
        tick();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        drain("t6_drain");

        // Reset mid-stream discards everything buffered.
        m_ready  = 1'b0;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        s0_data  = 32'hAAAA0000;
        s1_data  = 32'hBBBB0000;
        repeat (4) tick();
        check("t1_prefill_level", 64'(level), 64'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t1_rst");
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        m_ready  = 1'b1;
        s1_valid = 1'b1;
        s1_data  = 32'hA5;
        #1;
        check("t1_new_word_ready", 64'(s1_ready), 64'd1);
        tick();
        s1_valid = 1'b0;
        drain("t1_drain");
        repeat (4) tick();
        check("t1_nothing_else", 64'(m_valid), 64'd0);

        // Both requesters held: grants alternate starting with s0.
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        m_ready  = 1'b1;
        exp_src  = 1'b0;
        ngr = 0;
        cyc = 0;
        while (ngr < 8 && cyc < 60) begin
            s0_data = 32'h100 + 32'(ngr);
            s1_data = 32'h200 + 32'(ngr);
            #1;
            if (s0_ready || s1_ready) begin
                check("t3_onehot", 64'(s0_ready & s1_ready), 64'd0);
                check("t3_grant_src", 64'(s1_ready), 64'(exp_src));
                exp_src = ~exp_src;
                ngr++;
            end
            tick();
            cyc++;
        end
        check("t3_grant_count", 64'(ngr), 64'd8);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        drain("t3_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
